// File: rtl/serial_cfg_if.sv
// Command/response handshake and serial pin bundle for serial_cfg_master.
// The master modport is the block side; slave is the command issuer plus serial slave.
interface serial_cfg_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rw;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [REG_WIDTH-1:0]  cmd_wdata;
    logic                  rsp_valid;
    logic [REG_WIDTH-1:0]  rsp_rdata;
    logic                  busy;
    logic                  strobe;
    logic                  wr_en;
    logic                  din;
    logic                  sin;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, sin,
        output cmd_ready, rsp_valid, rsp_rdata, busy, strobe, wr_en, din
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, sin,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, strobe, wr_en, din
    );
endinterface

// File: rtl/serial_cfg_master.sv
// Serial register-access master: setup gap, strobe, LSB-first frame shift, one-cycle response.
// All outputs are registered and derived from the next state so they align with the FSM state.
module serial_cfg_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    serial_cfg_if.master    bus
);
    localparam int FRAME_W = ADDR_WIDTH + REG_WIDTH;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] CAP_START  = BIT_W'(ADDR_WIDTH);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                 state_r, next_state_s;
    logic [GAP_W-1:0]       gap_cnt_r, gap_next_s;
    logic [BIT_W-1:0]       bit_cnt_r, bit_next_s;
    logic                   accept_s;
    logic                   shift_en_s;
    logic                   din_next_s;
    logic                   rw_r;
    logic [FRAME_W-1:0]     frame_r;
    logic [REG_WIDTH-1:0]   cap_r, cap_next_s;
    logic                   cmd_ready_r, rsp_valid_r, busy_r, strobe_r, wr_en_r, din_r;
    logic [REG_WIDTH-1:0]   rsp_rdata_r;

    // Next-state and counter sequencing.
    always_comb begin
        next_state_s = state_r;
        gap_next_s   = gap_cnt_r;
        bit_next_s   = bit_cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = SETUP;
                    gap_next_s   = '0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    next_state_s = STROBE;
                    gap_next_s   = '0;
                end else begin
                    gap_next_s   = gap_cnt_r + GAP_W'(1);
                end
            end
            STROBE: begin
                next_state_s = SHIFT;
                bit_next_s   = '0;
            end
            SHIFT: begin
                if (bit_cnt_r == BIT_LAST) begin
                    next_state_s = DONE;
                    bit_next_s   = '0;
                end else begin
                    bit_next_s   = bit_cnt_r + BIT_W'(1);
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
                gap_next_s   = '0;
                bit_next_s   = '0;
            end
        endcase
    end

    // Read-capture enable, shifted capture value and next serial output bit.
    always_comb begin
        shift_en_s = (state_r == SHIFT) && !rw_r && (bit_cnt_r >= CAP_START);
        cap_next_s = {bus.sin, cap_r[REG_WIDTH-1:1]};
        if (next_state_s == SHIFT) begin
            din_next_s = frame_r[bit_next_s];
        end else begin
            din_next_s = 1'b0;
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            gap_cnt_r <= '0;
            bit_cnt_r <= '0;
        end else begin
            state_r   <= next_state_s;
            gap_cnt_r <= gap_next_s;
            bit_cnt_r <= bit_next_s;
        end
    end

    // Command latch and read-data capture; fields only move on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw_r    <= 1'b0;
            frame_r <= '0;
            cap_r   <= '0;
        end else if (accept_s) begin
            rw_r    <= bus.cmd_rw;
            frame_r <= bus.cmd_rw ? {bus.cmd_addr, bus.cmd_wdata}
                                  : {{REG_WIDTH{1'b0}}, bus.cmd_addr};
            cap_r   <= '0;
        end else if (shift_en_s) begin
            cap_r   <= cap_next_s;
        end else begin
            cap_r   <= cap_r;
        end
    end

    // Registered outputs; wr_en only updates on acceptance so it holds through IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            busy_r      <= 1'b0;
            strobe_r    <= 1'b0;
            wr_en_r     <= 1'b0;
            din_r       <= 1'b0;
        end else begin
            cmd_ready_r <= (next_state_s == IDLE);
            rsp_valid_r <= (next_state_s == DONE);
            busy_r      <= (next_state_s != IDLE);
            strobe_r    <= (next_state_s == STROBE);
            din_r       <= din_next_s;
            wr_en_r     <= accept_s ? bus.cmd_rw : wr_en_r;
            if (next_state_s == DONE) begin
                rsp_rdata_r <= rw_r ? {REG_WIDTH{1'b0}} : cap_next_s;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.busy      = busy_r;
    assign bus.strobe    = strobe_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.din       = din_r;
endmodule

// File: tb/tb_serial_cfg_master.sv
// Directed bench for serial_cfg_master: vector table of frames, busy-hold, mid-frame reset,
// and a 17-location write/read loopback through a small serial slave model.
module tb_serial_cfg_master;
    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  sin_word;
        logic [12:0] exp_din;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic [7:0] mem [32];

    serial_cfg_if #(.ADDR_WIDTH(5), .REG_WIDTH(8)) bus ();

    serial_cfg_master #(.ADDR_WIDTH(5), .REG_WIDTH(8), .GAP_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge of the IDLE cycle after DONE.
    task automatic run_cmd(input vec_t v, input bit hold, input bit use_model);
        logic [12:0] din_seen;
        logic [7:0]  word;
        int          k;
        din_seen      = '0;
        word          = v.sin_word;
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = v.rw;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.sin       = 1'b1;
        check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            bus.cmd_rw    = ~v.rw;
            bus.cmd_addr  = v.addr ^ 5'h1F;
            bus.cmd_wdata = ~v.wdata;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check("strobe", 32'(bus.strobe), 32'(c == 5));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(c == 19));
            check("busy", 32'(bus.busy), 32'(c <= 19));
            check("cmd_ready", 32'(bus.cmd_ready), 32'(c == 20));
            check("wr_en", 32'(bus.wr_en), 32'(v.rw));
            k = c - 6;
            if (k >= 0 && k <= 12) begin
                din_seen[4'(k)] = bus.din;
            end else begin
                check("din_quiet", 32'(bus.din), 32'd0);
            end
            if (c >= 19) begin
                check("rsp_rdata", 32'(bus.rsp_rdata), v.rw ? 32'd0 : 32'(v.exp_rdata));
            end
            if (use_model && k == 4) begin
                word = mem[din_seen[4:0]];
            end
            if (k >= 5 && k <= 12 && !v.rw) begin
                bus.sin = word[3'(k - 5)];
            end else begin
                bus.sin = 1'b1;
            end
        end
        check("din_frame", 32'(din_seen), 32'(v.exp_din));
        if (use_model && v.rw) begin
            mem[din_seen[12:8]] = din_seen[7:0];
        end
    endtask

    vec_t tbl [8];
    vec_t v;
    logic [7:0] lb_data [17];
    logic [7:0] lfsr;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        //            rw    addr   wdata  sin    exp_din    exp_rdata
        tbl[0] = '{1'b1, 5'h03, 8'hC6, 8'h00, 13'h03C6, 8'h00};
        tbl[1] = '{1'b0, 5'h05, 8'h00, 8'h2B, 13'h0005, 8'h2B};
        tbl[2] = '{1'b1, 5'h1F, 8'hFF, 8'h00, 13'h1FFF, 8'h00};
        tbl[3] = '{1'b0, 5'h1F, 8'hFF, 8'h80, 13'h001F, 8'h80};
        tbl[4] = '{1'b1, 5'h10, 8'h01, 8'hFF, 13'h1001, 8'h00};
        tbl[5] = '{1'b0, 5'h0A, 8'h3C, 8'hA5, 13'h000A, 8'hA5};
        tbl[6] = '{1'b1, 5'h00, 8'h00, 8'h00, 13'h0000, 8'h00};
        tbl[7] = '{1'b0, 5'h00, 8'h00, 8'h01, 13'h0000, 8'h01};

        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = 5'h00;
        bus.cmd_wdata = 8'h00;
        bus.sin       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_strobe", 32'(bus.strobe), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_din", 32'(bus.din), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i], 1'b0, 1'b0);
        end

        // Busy-hold: altered fields stay on cmd_* and must not leak into the first frame.
        run_cmd(tbl[3], 1'b1, 1'b0);
        run_cmd(tbl[0], 1'b0, 1'b0);

        // Mid-frame reset at SHIFT k=6 of a write whose din is 1 there.
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = 1'b1;
        bus.cmd_addr  = 5'h1F;
        bus.cmd_wdata = 8'hFF;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_rst_din", 32'(bus.din), 32'd1);
        check("pre_rst_wr_en", 32'(bus.wr_en), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_din", 32'(bus.din), 32'd0);
        check("abort_wr_en", 32'(bus.wr_en), 32'd0);
        check("abort_strobe", 32'(bus.strobe), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("post_rst_busy", 32'(bus.busy), 32'd0);
        end
        v = '{1'b1, 5'h01, 8'h5D, 8'h00, 13'h015D, 8'h00};
        run_cmd(v, 1'b0, 1'b0);

        // Loopback through the slave model.
        lfsr = 8'hA7;
        for (int i = 0; i < 17; i++) begin
            lfsr       = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            lb_data[i] = lfsr;
        end
        for (int i = 0; i < 17; i++) begin
            v = '{1'b1, 5'(i), lb_data[i], 8'h00, {5'(i), lb_data[i]}, 8'h00};
            run_cmd(v, 1'b0, 1'b1);
        end
        for (int i = 0; i < 17; i++) begin
            v = '{1'b0, 5'(i), 8'h00, 8'h00, {8'h00, 5'(i)}, lb_data[i]};
            run_cmd(v, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_cfg_master.md
SERIAL_CFG_MASTER -- requirements
Module: serial_cfg_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 The block SHALL have parameter REG_WIDTH, default 8, register data width; FRAME_W = ADDR_WIDTH+REG_WIDTH (13).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 4, number of setup cycles before strobe; legal range >= 1.
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port cmd_valid  input  1  command request.
REQ-007 The block SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-008 The block SHALL have port cmd_rw  input  1  1=write, 0=read.
REQ-009 The block SHALL have port cmd_addr  input  ADDR_WIDTH  target register address.
REQ-010 The block SHALL have port cmd_wdata  input  REG_WIDTH  write data.
REQ-011 The block SHALL have port rsp_valid  output  1  one-cycle completion pulse, both reads and writes.
REQ-012 The block SHALL have port rsp_rdata  output  REG_WIDTH  read data; valid while rsp_valid=1.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port strobe  output  1  frame-start pulse to serial slave.
REQ-015 The block SHALL have port wr_en  output  1  frame direction to slave, 1=write.
REQ-016 The block SHALL have port din  output  1  serial data to slave.
REQ-017 The block SHALL have port sin  input  1  serial read data from slave dout.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, STROBE, SHIFT, DONE.
REQ-019 IDLE: cmd_ready=1; on accept, cmd_rw/cmd_addr/cmd_wdata SHALL be latched and FSM SHALL go to SETUP.
REQ-020 SETUP SHALL last exactly GAP_CYCLES cycles, with wr_en = latched cmd_rw, strobe=0, din=0.
REQ-021 STROBE SHALL last exactly 1 cycle with strobe=1, din=0.
REQ-022 SHIFT SHALL last exactly FRAME_W cycles, indexed k=0..FRAME_W-1 by a bit counter, then go to DONE.
REQ-023 Write frame: din SHALL be wdata[k] for k<REG_WIDTH, then addr[k-REG_WIDTH]; LSB first, data before address.
REQ-024 Read frame: din SHALL be addr[k] for k<ADDR_WIDTH, then 0; sin SHALL be sampled at the rising edge ending cycle k into rdata[k-ADDR_WIDTH] for k>=ADDR_WIDTH.
REQ-025 DONE SHALL last 1 cycle with rsp_valid=1 and rsp_rdata = captured data (reads) or 0 (writes), then return to IDLE.
REQ-026 Latency: for acceptance at the edge ending cycle T, strobe SHALL be high in cycle T+GAP_CYCLES+1 and rsp_valid in cycle T+GAP_CYCLES+FRAME_W+2 (T+19 at defaults).
REQ-027 wr_en SHALL change only on entry to SETUP and SHALL hold its value through IDLE until the next command.
REQ-028 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE SHALL be ignored and SHALL NOT alter latched fields.
REQ-029 The minimum command-to-command spacing SHALL be GAP_CYCLES+FRAME_W+3 cycles (next acceptance in the IDLE cycle after DONE).
REQ-030 rsp_rdata SHALL hold its value after DONE until the next DONE.

Reset
REQ-031 While rst=0, the block SHALL force: state IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, strobe=0, wr_en=0, din=0, bit counter 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately with no rsp_valid pulse; the first command after release SHALL run a complete, correct frame.

Verification
REQ-033 Write addr 0x03 data 0xC6 -> wr_en=1 from T+1; strobe high at T+5; din over 13 cycles = 0,1,1,0,0,0,1,1,1,1,0,0,0; rsp_valid at T+19; rsp_rdata=0.
REQ-034 Read addr 0x05, sin model returns 0x2B LSB first on k=5..12 -> wr_en=0; din = 1,0,1,0,0 then eight 0s; rsp_rdata=0x2B with rsp_valid at T+19.
REQ-035 cmd_valid held high with a different addr/data during busy -> no acceptance, cmd_ready=0, first frame bits unchanged; second command accepted in IDLE cycle after DONE.
REQ-036 rst driven low at SHIFT k=6 -> strobe/wr_en/din=0 asynchronously, no rsp_valid; after release, write addr 0x01 data 0x5D completes correctly.
REQ-037 Loopback with slave model: write 17 locations (addr 0..16, data from fixed seed), read back all 17 -> every rsp_rdata equals written data.
